// File: rtl/driver_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : driver_pkg
// Description : Shared types and constants for the LED driver controller.
//               It holds the controller state encoding, the LAT command
//               widths (counted in SCLK pulses) and the channel count of one
//               TLC5957-class driver.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
package driver_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CFG_EN    = 3'd1,
    CFG_WRITE = 3'd2,
    STREAM    = 3'd3,
    BLANK     = 3'd4
  } drv_state_t;

  // LAT high time, in SCLK pulses, for each driver command
  localparam int WRTGS_LAT   = 1;
  localparam int LATGS_LAT   = 3;
  localparam int WRTFC_LAT   = 5;
  localparam int FCWRTEN_LAT = 15;

  // grayscale channels per driver (16 RGB LEDs)
  localparam int CHANNELS = 48;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lat_window_gen.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : lat_window_gen
// Description : Asserts LAT for the final i_width strobes of a sequence whose
//               strobes are numbered 0..i_last by i_count.  One instance serves
//               the FCWRTEN, WRTFC, WRTGS and LATGS commands.
// Ports       : i_count  strobe index of the current cycle
//               i_last   index of the final strobe of the sequence
//               i_width  number of trailing strobes with LAT high (0 = none)
//               o_lat    LAT request for this strobe
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module lat_window_gen #(
  parameter int CNT_W = 8
) (
  input  logic [CNT_W-1:0] i_count,
  input  logic [CNT_W-1:0] i_last,
  input  logic [CNT_W-1:0] i_width,
  output logic             o_lat
);

  // One extra bit so count + width cannot wrap around
  logic [CNT_W:0] w_count_plus_width;

  assign w_count_plus_width = {1'b0, i_count} + {1'b0, i_width};

  // count in (last - width, last]  <=>  count <= last && count + width > last
  assign o_lat = (i_count <= i_last) && (w_count_plus_width > {1'b0, i_last});

endmodule
`default_nettype wire

// File: rtl/driver_controller.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : driver_controller
// Description : Drives NB_DRIVERS daisy-free TLC5957-class LED drivers.  It
//               paces the upstream framebuffer with driver_ready, forwards the
//               per-cycle data word onto the SIN lines, builds the LAT
//               command windows (FCWRTEN/WRTFC, WRTGS/LATGS), inserts the
//               inter-column blanking interval and rewrites the common
//               configuration register at column boundaries.
// Ports       : clk_33                  system clock
//               nrst                    asynchronous active-low reset
//               data                    one bit per driver, valid 1 cycle
//                                       after driver_ready
//               driver_ready            request one data word next cycle
//               config_data             configuration word, MSB first
//               new_config_available    capture pulse for config_data
//               new_configuration_ready pulse when WRTFC completes
//               drv_sin                 serial data to the drivers
//               drv_sclk_en             forward one SCLK pulse this cycle
//               drv_lat                 LAT line
//               drv_gclk_en             GCLK forwarding enable
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module driver_controller
  import driver_pkg::*;
#(
  parameter int POKER_MODE      = 9,
  parameter int LED_PER_DRIVER  = CHANNELS / 3,
  parameter int NB_DRIVERS      = 30,
  parameter int BLANKING_CYCLES = 72,
  parameter int CONFIG_WIDTH    = 48
) (
  input  logic                    clk_33,
  input  logic                    nrst,
  input  logic [NB_DRIVERS-1:0]   data,
  output logic                    driver_ready,
  input  logic [CONFIG_WIDTH-1:0] config_data,
  input  logic                    new_config_available,
  output logic                    new_configuration_ready,
  output logic [NB_DRIVERS-1:0]   drv_sin,
  output logic                    drv_sclk_en,
  output logic                    drv_lat,
  output logic                    drv_gclk_en
);

  localparam int C_CHANNELS  = 3 * LED_PER_DRIVER;
  localparam int C_REQ_TOTAL = C_CHANNELS * POKER_MODE;
  localparam int CNT_W   = $clog2(max_int(max_int(BLANKING_CYCLES, CONFIG_WIDTH),
                                          max_int(C_CHANNELS, FCWRTEN_LAT + 1)) + 1);
  localparam int CHAN_W  = $clog2(C_CHANNELS);
  localparam int PLANE_W = $clog2(POKER_MODE + 1);
  localparam int REQ_W   = $clog2(C_REQ_TOTAL + 1);

  localparam logic [CNT_W-1:0]   C_FCWRTEN_LAST = CNT_W'(FCWRTEN_LAT - 1);
  localparam logic [CNT_W-1:0]   C_FCWRTEN_END  = CNT_W'(FCWRTEN_LAT);
  localparam logic [CNT_W-1:0]   C_FCWRTEN_W    = CNT_W'(FCWRTEN_LAT);
  localparam logic [CNT_W-1:0]   C_WRTFC_LAST   = CNT_W'(CONFIG_WIDTH - 1);
  localparam logic [CNT_W-1:0]   C_WRTFC_W      = CNT_W'(WRTFC_LAT);
  localparam logic [CNT_W-1:0]   C_CHAN_LAST_W  = CNT_W'(C_CHANNELS - 1);
  localparam logic [CNT_W-1:0]   C_WRTGS_W      = CNT_W'(WRTGS_LAT);
  localparam logic [CNT_W-1:0]   C_LATGS_W      = CNT_W'(LATGS_LAT);
  localparam logic [CNT_W-1:0]   C_BLANK_LAST   = CNT_W'(BLANKING_CYCLES - 1);
  localparam logic [CHAN_W-1:0]  C_CHAN_LAST    = CHAN_W'(C_CHANNELS - 1);
  localparam logic [PLANE_W-1:0] C_PLANE_LAST   = PLANE_W'(POKER_MODE - 1);
  localparam logic [REQ_W-1:0]   C_REQ_TOTAL_V  = REQ_W'(C_REQ_TOTAL);

  drv_state_t r_state;
  drv_state_t w_next_state;

  logic [CNT_W-1:0]        r_cnt;
  logic [REQ_W-1:0]        r_req_cnt;
  logic [CHAN_W-1:0]       r_chan_cnt;
  logic [PLANE_W-1:0]      r_plane_cnt;
  logic                    r_ready_d;
  logic                    r_config_pending;
  logic                    r_configured;
  logic                    r_gclk_seen;
  logic [CONFIG_WIDTH-1:0] r_cfg_reg;
  logic [CONFIG_WIDTH-1:0] r_cfg_shift;

  logic [NB_DRIVERS-1:0]   r_drv_sin;
  logic                    r_drv_sclk_en;
  logic                    r_drv_lat;
  logic                    r_drv_gclk_en;
  logic                    r_new_cfg_ready;

  logic                    w_cfg_en_done;
  logic                    w_cfg_write_done;
  logic                    w_last_chan;
  logic                    w_last_plane;
  logic                    w_column_done;
  logic                    w_blank_done;
  logic                    w_strobe;

  logic [CNT_W-1:0]        w_win_count;
  logic [CNT_W-1:0]        w_win_last;
  logic [CNT_W-1:0]        w_win_width;
  logic                    w_win_lat;

  logic [NB_DRIVERS-1:0]   w_sin;
  logic                    w_sclk_en;
  logic                    w_lat;
  logic                    w_gclk_en;

  // driver_ready delayed by one cycle marks the cycle in which data is valid
  assign w_strobe         = r_ready_d;
  assign w_last_chan      = (r_chan_cnt == C_CHAN_LAST);
  assign w_last_plane     = (r_plane_cnt == C_PLANE_LAST);
  assign w_cfg_en_done    = (r_state == CFG_EN)    && (r_cnt == C_FCWRTEN_END);
  assign w_cfg_write_done = (r_state == CFG_WRITE) && (r_cnt == C_WRTFC_LAST);
  assign w_column_done    = (r_state == STREAM) && w_strobe && w_last_chan && w_last_plane;
  assign w_blank_done     = (r_state == BLANK)  && (r_cnt == C_BLANK_LAST);

  assign driver_ready = (r_state == STREAM) && (r_req_cnt != C_REQ_TOTAL_V);

  //--------------------------------------------------------------------------
  // FSM: state register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk_33 or negedge nrst) begin
    if (!nrst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  //--------------------------------------------------------------------------
  // FSM: next-state logic
  //--------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (r_config_pending) begin
          w_next_state = CFG_EN;
        end else if (r_configured) begin
          w_next_state = STREAM;
        end
      end
      CFG_EN: begin
        if (w_cfg_en_done) w_next_state = CFG_WRITE;
      end
      CFG_WRITE: begin
        if (w_cfg_write_done) w_next_state = STREAM;
      end
      STREAM: begin
        if (w_column_done) w_next_state = BLANK;
      end
      BLANK: begin
        if (w_blank_done) w_next_state = r_config_pending ? CFG_EN : STREAM;
      end
      default: w_next_state = IDLE;
    endcase
  end

  //--------------------------------------------------------------------------
  // LAT window selection: one generator shared by all four commands
  //--------------------------------------------------------------------------
  always_comb begin
    w_win_count = '0;
    w_win_last  = '0;
    w_win_width = '0;
    case (r_state)
      CFG_EN: begin
        w_win_count = r_cnt;
        w_win_last  = C_FCWRTEN_LAST;
        w_win_width = C_FCWRTEN_W;
      end
      CFG_WRITE: begin
        w_win_count = r_cnt;
        w_win_last  = C_WRTFC_LAST;
        w_win_width = C_WRTFC_W;
      end
      STREAM: begin
        w_win_count = CNT_W'(r_chan_cnt);
        w_win_last  = C_CHAN_LAST_W;
        // the last bit plane closes the column with LATGS instead of WRTGS
        w_win_width = w_last_plane ? C_LATGS_W : C_WRTGS_W;
      end
      default: begin
        w_win_count = '0;
      end
    endcase
  end

  lat_window_gen #(
    .CNT_W (CNT_W)
  ) u_lat_window_gen (
    .i_count (w_win_count),
    .i_last  (w_win_last),
    .i_width (w_win_width),
    .o_lat   (w_win_lat)
  );

  //--------------------------------------------------------------------------
  // FSM: output logic (registered below so SIN, SCLK and LAT stay aligned)
  //--------------------------------------------------------------------------
  always_comb begin
    w_sin     = '0;
    w_sclk_en = 1'b0;
    w_lat     = 1'b0;
    w_gclk_en = 1'b0;
    case (r_state)
      CFG_EN: begin
        // the final counter value is the one-cycle gap before WRTFC
        w_sclk_en = (r_cnt < C_FCWRTEN_END);
        w_lat     = w_win_lat;
      end
      CFG_WRITE: begin
        w_sclk_en = 1'b1;
        w_sin     = {NB_DRIVERS{r_cfg_shift[CONFIG_WIDTH-1]}};
        w_lat     = w_win_lat;
      end
      STREAM: begin
        w_sclk_en = w_strobe;
        w_sin     = w_strobe ? data : '0;
        w_lat     = w_strobe & w_win_lat;
        w_gclk_en = r_gclk_seen;
      end
      BLANK: begin
        w_gclk_en = r_gclk_seen;
      end
      default: begin
        w_sclk_en = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_33 or negedge nrst) begin
    if (!nrst) begin
      r_drv_sin       <= '0;
      r_drv_sclk_en   <= 1'b0;
      r_drv_lat       <= 1'b0;
      r_drv_gclk_en   <= 1'b0;
      r_new_cfg_ready <= 1'b0;
    end else begin
      r_drv_sin       <= w_sin;
      r_drv_sclk_en   <= w_sclk_en;
      r_drv_lat       <= w_lat;
      r_drv_gclk_en   <= w_gclk_en;
      r_new_cfg_ready <= w_cfg_write_done;
    end
  end

  //--------------------------------------------------------------------------
  // Counters
  //--------------------------------------------------------------------------
  always_ff @(posedge clk_33 or negedge nrst) begin
    if (!nrst) begin
      r_cnt       <= '0;
      r_req_cnt   <= '0;
      r_chan_cnt  <= '0;
      r_plane_cnt <= '0;
      r_ready_d   <= 1'b0;
    end else begin
      r_ready_d <= driver_ready;

      // phase counter restarts on every state change
      if (w_next_state != r_state) begin
        r_cnt <= '0;
      end else if ((r_state == CFG_EN) || (r_state == CFG_WRITE) || (r_state == BLANK)) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (r_state != STREAM) begin
        r_req_cnt <= '0;
      end else if (driver_ready) begin
        r_req_cnt <= r_req_cnt + 1'b1;
      end

      if (r_state != STREAM) begin
        r_chan_cnt  <= '0;
        r_plane_cnt <= '0;
      end else if (w_strobe) begin
        if (w_last_chan) begin
          r_chan_cnt  <= '0;
          r_plane_cnt <= w_last_plane ? '0 : r_plane_cnt + 1'b1;
        end else begin
          r_chan_cnt  <= r_chan_cnt + 1'b1;
        end
      end
    end
  end

  //--------------------------------------------------------------------------
  // Configuration capture and flags
  //--------------------------------------------------------------------------
  always_ff @(posedge clk_33 or negedge nrst) begin
    if (!nrst) begin
      r_cfg_reg        <= '0;
      r_cfg_shift      <= '0;
      r_config_pending <= 1'b0;
      r_configured     <= 1'b0;
      r_gclk_seen      <= 1'b0;
    end else begin
      // a capture coinciding with the end of WRTFC keeps the request pending
      if (new_config_available) begin
        r_cfg_reg        <= config_data;
        r_config_pending <= 1'b1;
      end else if (w_cfg_write_done) begin
        r_config_pending <= 1'b0;
      end

      // snapshot at the start of WRTFC so a late capture cannot tear the word
      if (w_cfg_en_done) begin
        r_cfg_shift <= r_cfg_reg;
      end else if (r_state == CFG_WRITE) begin
        r_cfg_shift <= {r_cfg_shift[CONFIG_WIDTH-2:0], 1'b0};
      end

      if (w_cfg_write_done) r_configured <= 1'b1;
      if (w_column_done)    r_gclk_seen  <= 1'b1;
    end
  end

  assign drv_sin                 = r_drv_sin;
  assign drv_sclk_en             = r_drv_sclk_en;
  assign drv_lat                 = r_drv_lat;
  assign drv_gclk_en             = r_drv_gclk_en;
  assign new_configuration_ready = r_new_cfg_ready;

endmodule
`default_nettype wire

// File: tb/tb_driver_controller.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_driver_controller
// Description : Self-checking bench for driver_controller.  Expected SCLK
//               pulses (SIN word, LAT, preceding idle gap) are queued from the
//               driver command rules; a monitor pops one per observed pulse.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_driver_controller;

  localparam int NB      = 30;
  localparam int CW      = 48;
  localparam int CH      = 48;
  localparam int PM      = 9;
  localparam int COL     = CH * PM;       // 432 strobes per column
  localparam int PERIOD  = COL + 72 + 1;  // 505 cycles per column
  localparam int COL_GAP = PERIOD - COL;  // idle SCLK cycles between columns

  logic          clk_33;
  logic          nrst;
  logic [NB-1:0] data;
  logic          driver_ready;
  logic [CW-1:0] config_data;
  logic          new_config_available;
  logic          new_configuration_ready;
  logic [NB-1:0] drv_sin;
  logic          drv_sclk_en;
  logic          drv_lat;
  logic          drv_gclk_en;

  driver_controller dut (
    .clk_33                  (clk_33),
    .nrst                    (nrst),
    .data                    (data),
    .driver_ready            (driver_ready),
    .config_data             (config_data),
    .new_config_available    (new_config_available),
    .new_configuration_ready (new_configuration_ready),
    .drv_sin                 (drv_sin),
    .drv_sclk_en             (drv_sclk_en),
    .drv_lat                 (drv_lat),
    .drv_gclk_en             (drv_gclk_en)
  );

  initial begin
    clk_33 = 1'b0;
    forever #15 clk_33 = ~clk_33;
  end

  // upstream: a fresh random word every cycle
  initial begin
    data = '0;
    forever begin
      @(posedge clk_33);
      #2 data = NB'($urandom);
    end
  end

  typedef struct {
    bit            is_stream;
    logic [NB-1:0] sin;
    bit            lat;
    int            gap;       // expected idle cycles before this pulse, -1 = any
    bit            col_last;
    bit            cfg_last;
  } item_t;

  item_t         exp_q[$];
  logic [NB-1:0] data_q[$];
  int            rise_q[$];

  int n_chk = 0;
  int n_err = 0;

  int  cyc          = 0;
  int  idle_run     = 1000;
  int  ready_run    = 0;
  bit  prev_ready   = 0;
  bit  latgs_done   = 0;
  int  last_cfg_cyc = -100;
  int  ncr_count    = 0;
  item_t         mon_it;
  logic [NB-1:0] mon_sin;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // expected FCWRTEN + WRTFC pulses for one configuration word
  task automatic push_cfg(input logic [CW-1:0] cfg);
    item_t it;
    for (int k = 0; k < 15; k++) begin
      it = '{is_stream: 0, sin: '0, lat: 1, gap: (k == 0) ? -1 : 0,
             col_last: 0, cfg_last: 0};
      exp_q.push_back(it);
    end
    for (int k = 0; k < CW; k++) begin
      it = '{is_stream: 0, sin: {NB{cfg[CW-1-k]}}, lat: (k >= CW - 5),
             gap: (k == 0) ? 1 : 0, col_last: 0, cfg_last: (k == CW - 1)};
      exp_q.push_back(it);
    end
  endtask

  // expected pulses of one column: WRTGS closes planes 0..7, LATGS plane 8
  task automatic push_column(input int first_gap);
    item_t it;
    for (int p = 0; p < PM; p++) begin
      for (int c = 0; c < CH; c++) begin
        it.is_stream = 1;
        it.sin       = '0;
        it.lat       = (p < PM - 1) ? (c == CH - 1) : (c >= CH - 3);
        it.gap       = (p == 0 && c == 0) ? first_gap : 0;
        it.col_last  = (p == PM - 1) && (c == CH - 1);
        it.cfg_last  = 0;
        exp_q.push_back(it);
      end
    end
  endtask

  always @(negedge clk_33) begin
    if (!nrst) begin
      idle_run   = 1000;
      ready_run  = 0;
      prev_ready = 0;
    end else begin
      cyc++;
      if (prev_ready) data_q.push_back(data);
      if (driver_ready) ready_run++;
      if (driver_ready && !prev_ready) rise_q.push_back(cyc);
      if (!driver_ready && prev_ready) begin
        chk_eq("ready_run", ready_run, COL);
        ready_run = 0;
      end
      prev_ready = driver_ready;

      if (drv_sclk_en) begin
        if (exp_q.size() == 0) begin
          chk_eq("unexpected_sclk", drv_sclk_en, 0);
        end else begin
          mon_it = exp_q.pop_front();
          if (mon_it.gap >= 0) chk_eq("sclk_gap", idle_run, mon_it.gap);
          if (mon_it.is_stream) begin
            chk_eq("data_q_depth", (data_q.size() > 0), 1);
            mon_sin = (data_q.size() > 0) ? data_q.pop_front() : 'x;
            chk_eq("stream_sin", drv_sin, mon_sin);
            chk_eq("stream_gclk", drv_gclk_en, latgs_done);
            if (mon_it.col_last) latgs_done = 1;
          end else begin
            chk_eq("cfg_sin", drv_sin, mon_it.sin);
            chk_eq("cfg_gclk", drv_gclk_en, 0);
          end
          chk_eq("lat", drv_lat, mon_it.lat);
          if (mon_it.cfg_last) last_cfg_cyc = cyc;
        end
        idle_run = 0;
      end else begin
        idle_run++;
        if (drv_lat) chk_eq("lat_without_sclk", drv_lat, 0);
      end

      if (new_configuration_ready) begin
        ncr_count++;
        chk_eq("ncr_align", ((cyc - last_cfg_cyc) <= 1), 1);
      end
    end
  end

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk_33);
      n++;
    end
    chk_eq("drain_left", exp_q.size(), 0);
  endtask

  task automatic pulse_cfg(input logic [CW-1:0] cfg);
    @(negedge clk_33);
    config_data          = cfg;
    new_config_available = 1'b1;
    @(negedge clk_33);
    new_config_available = 1'b0;
  endtask

  task automatic check_all_zero(input string phase);
    chk_eq({phase, "_ready"}, driver_ready, 0);
    chk_eq({phase, "_sclk"},  drv_sclk_en, 0);
    chk_eq({phase, "_lat"},   drv_lat, 0);
    chk_eq({phase, "_gclk"},  drv_gclk_en, 0);
    chk_eq({phase, "_sin"},   drv_sin, 0);
    chk_eq({phase, "_ncr"},   new_configuration_ready, 0);
  endtask

  logic [CW-1:0] cfg_b, cfg_c, cfg_e;
  int            n_wait, n_busy;

  initial begin
    nrst                 = 1'b0;
    config_data          = '0;
    new_config_available = 1'b0;
    repeat (4) @(negedge clk_33);
    check_all_zero("reset");
    nrst = 1'b1;

    // no configuration yet: stays idle
    repeat (20) @(negedge clk_33);
    chk_eq("idle_no_cfg_ready", driver_ready, 0);

    // first configuration, then the first column
    push_cfg(48'hA5A5_0000_FFFF);
    push_column(-1);
    pulse_cfg(48'hA5A5_0000_FFFF);
    wait_drain(2000);
    chk_eq("ncr_count_1", ncr_count, 1);

    // two more back-to-back columns, period measured between ready rises
    push_column(COL_GAP);
    wait_drain(1000);
    push_column(COL_GAP);
    wait_drain(1000);
    chk_eq("rise_count", rise_q.size(), 3);
    if (rise_q.size() >= 3) begin
      chk_eq("period_1", rise_q[1] - rise_q[0], PERIOD);
      chk_eq("period_2", rise_q[2] - rise_q[1], PERIOD);
    end

    // new configuration mid-column: column completes, then rewrite
    cfg_b = {16'($urandom), $urandom};
    push_column(COL_GAP);
    repeat (100) @(negedge clk_33);
    chk_eq("mid_stream_ready", driver_ready, 1);
    pulse_cfg(cfg_b);
    wait_drain(1000);
    push_cfg(cfg_b);
    push_column(-1);
    wait_drain(2000);
    chk_eq("ncr_count_2", ncr_count, 2);

    // two captures before the boundary: only the latest is written
    cfg_c = {16'($urandom), $urandom};
    cfg_e = ~cfg_c;
    push_column(COL_GAP);
    repeat (150) @(negedge clk_33);
    pulse_cfg(cfg_c);
    repeat (10) @(negedge clk_33);
    pulse_cfg(cfg_e);
    wait_drain(1000);
    push_cfg(cfg_e);
    push_column(-1);
    wait_drain(2000);
    chk_eq("ncr_count_3", ncr_count, 3);

    // asynchronous reset around channel 20 of a column
    push_column(COL_GAP);
    n_wait = 0;
    while (exp_q.size() > COL - 21 && n_wait < 1000) begin
      @(negedge clk_33);
      n_wait++;
    end
    chk_eq("reached_chan20", (exp_q.size() <= COL - 21), 1);
    #3 nrst = 1'b0;
    #1 check_all_zero("async_rst");
    exp_q.delete();
    data_q.delete();
    latgs_done = 0;
    repeat (3) @(negedge clk_33);
    nrst = 1'b1;
    n_busy = 0;
    repeat (300) begin
      @(negedge clk_33);
      n_busy += int'(driver_ready) + int'(drv_sclk_en) + int'(drv_lat);
    end
    chk_eq("idle_after_reset", n_busy, 0);

    // recovers once a new configuration arrives
    push_cfg(48'h0123_4567_89AB);
    push_column(-1);
    pulse_cfg(48'h0123_4567_89AB);
    wait_drain(2000);
    chk_eq("ncr_count_4", ncr_count, 4);
    chk_eq("data_q_left", data_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/driver_controller.md
Name: driver_controller

Overview:
- Downstream consumer of the framebuffer data stage. Drives the 30 TLC5957-class LED drivers.
- Produces `driver_ready` to pace the 30-bit per-cycle `data` stream from upstream, and forwards it to the 30 SIN lines.
- Generates the LAT command windows (WRTGS/LATGS, FCWRTEN/WRTFC) and the SCLK/GCLK enables.
- Inserts the inter-column blanking interval and writes the common configuration register at frame boundaries.

Parameters:
- POKER_MODE, 9, grayscale bits sent per LED channel per column.
- LED_PER_DRIVER, 16, LEDs per driver; channels = 3*LED_PER_DRIVER = 48.
- NB_DRIVERS, 30, number of driver SIN lines.
- BLANKING_CYCLES, 72, clk_33 cycles with SCLK idle after each LATGS.
- CONFIG_WIDTH, 48, driver function-control register width.

Ports:
- clk_33  in  1  system clock; all SCLK/GCLK edges derive from it.
- nrst  in  1  asynchronous active-low reset.
- data  in  NB_DRIVERS  one bit per driver; valid 1 cycle after driver_ready.
- driver_ready  out  1  request one data word next cycle.
- config_data  in  CONFIG_WIDTH  driver configuration, MSB shifted first.
- new_config_available  in  1  1-cycle pulse; capture config_data.
- new_configuration_ready  out  1  1-cycle pulse when the WRTFC command completes.
- drv_sin  out  NB_DRIVERS  serial data to drivers.
- drv_sclk_en  out  1  forward one SCLK pulse this cycle (external clock-forwarding cell).
- drv_lat  out  1  LAT line.
- drv_gclk_en  out  1  GCLK forwarding enable.

Behaviour:
- Reset values: all outputs 0; state IDLE; config_pending 0.
- Reset mid-operation aborts immediately with no partial LAT (drv_lat forced to 0).

Configuration capture:
- new_config_available captures config_data into cfg_reg and sets config_pending.
- A later pulse overwrites cfg_reg (latest wins), in any state.
- If a capture coincides with CFG_WRITE completing, the capture wins: pending stays 1.

State IDLE:
- Wait for config_pending.
- Go to CFG_EN; go to STREAM only after the first configuration has been written.

State CFG_EN (FCWRTEN):
- 15 cycles: sclk_en=1, lat=1, sin=0.
- Then 1 cycle with sclk_en=0 and lat=0.
- Then go to CFG_WRITE.

State CFG_WRITE (WRTFC):
- 48 cycles: sclk_en=1; every drv_sin[i] = cfg_reg[47-k] on cycle k.
- lat=1 on cycles k=43..47.
- On exit: clear config_pending, pulse new_configuration_ready, set configured flag, go to STREAM.

State STREAM:
- driver_ready=1 for exactly 48*POKER_MODE = 432 consecutive cycles.
- The internal ready_d (driver_ready delayed 1) is the shift strobe.
- On ready_d: drv_sin <= data, drv_sclk_en <= 1, and the counters advance.
- Counters: chan_cnt 0..47, plane_cnt 0..POKER_MODE-1.
- lat=1 only on chan_cnt==47 for planes 0..POKER_MODE-2 (WRTGS, 1 SCLK).
- On the last plane, lat=1 for chan_cnt 45..47 (LATGS, 3 SCLK).
- drv_sin/sclk_en/lat are registered and aligned in the same cycle.

State BLANK:
- Entered after the last strobe; BLANKING_CYCLES cycles with sclk_en=0, lat=0, driver_ready=0.
- At the end: config_pending → CFG_EN, else → STREAM.

GCLK:
- drv_gclk_en=1 from the first LATGS onward, in STREAM and BLANK.
- drv_gclk_en=0 in IDLE, CFG_EN and CFG_WRITE.

Timing:
- Steady-state period = 432 + BLANKING_CYCLES + 1 = 505 cycles per column.
- driver_ready never drops mid-column; the upstream counters therefore stay aligned.

Decomposition:
- Package driver_pkg holds:
  - state enum {IDLE, CFG_EN, CFG_WRITE, STREAM, BLANK};
  - LAT widths WRTGS_LAT=1, LATGS_LAT=3, WRTFC_LAT=5, FCWRTEN_LAT=15;
  - CHANNELS=48.
- One natural sub-module, lat_window_gen: given a count, the last index and a width, it asserts lat for the final N strobes. It is shared by the WRTGS, LATGS and WRTFC paths.

Test Plan:
- Reset, then pulse new_config_available with cfg=48'hA5A5_0000_FFFF → 15 cycles lat=1/sclk_en=1, a 1-cycle gap, then 48 SIN bits matching cfg MSB-first on all 30 lines. lat is high on the last 5 bits, followed by a new_configuration_ready pulse.
- After config, drive data=30'h2AAAAAAA constant → drv_sin equals data one cycle after each driver_ready. Exactly 432 sclk_en pulses per column. lat pulses 8 times 1-wide, then once 3-wide.
- Measure column period → 505 cycles from driver_ready rise to the next rise; BLANK has sclk_en=0 for 72 cycles.
- Pulse new config during STREAM → the column completes unchanged; CFG_EN/CFG_WRITE runs after BLANK; drv_gclk_en=0 during the write, then resumes.
- Two config pulses before a boundary (A then B) → only B is shifted out; a single new_configuration_ready pulse.
- Assert nrst low mid-STREAM at chan_cnt=20 → all outputs 0 asynchronously; after release, IDLE until a new config arrives.
